// File: rtl/w_stage_writeback.sv
// W-stage writeback: decodes the retiring instruction, owns the GRF,
// serves two D-stage read ports with write-through bypass, exposes the
// effective W-stage write for forwarding and counts retired instructions.
module w_stage_writeback #(
    parameter int         NREG    = 32,
    parameter logic [5:0] COND_OP = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] EXT32_in,
    input  logic [31:0] AO_in,
    input  logic [31:0] RD_in,
    input  logic        con_in,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        w_we_out,
    output logic [4:0]  w_addr_out,
    output logic [31:0] w_data_out,
    output logic [31:0] instret_out
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic        w_dec_we;
    logic [4:0]  w_dec_addr;
    logic [31:0] w_sel_data;
    logic        w_eff_we;

    logic [31:0] r_grf [0:NREG-1];
    logic [31:0] r_instret;

    assign w_op    = instr_in[31:26];
    assign w_funct = instr_in[5:0];
    assign w_rt    = instr_in[20:16];
    assign w_rd    = instr_in[15:11];

    // Decode destination and writeback data; COND_OP is checked first so it
    // wins even if it is ever parameterised onto another opcode.
    always_comb begin
        w_dec_we   = 1'b0;
        w_dec_addr = 5'd0;
        w_sel_data = 32'd0;
        if (w_op == COND_OP) begin
            w_dec_we   = 1'b1;
            w_dec_addr = w_rt;
            w_sel_data = AO_in;
        end else begin
            case (w_op)
                OP_SPECIAL: begin
                    if (w_funct == FN_ADDU || w_funct == FN_SUBU) begin
                        w_dec_we   = 1'b1;
                        w_dec_addr = w_rd;
                        w_sel_data = AO_in;
                    end
                end
                OP_ORI, OP_LUI: begin
                    w_dec_we   = 1'b1;
                    w_dec_addr = w_rt;
                    w_sel_data = AO_in;
                end
                OP_LW: begin
                    w_dec_we   = 1'b1;
                    w_dec_addr = w_rt;
                    w_sel_data = RD_in;
                end
                OP_JAL: begin
                    w_dec_we   = 1'b1;
                    w_dec_addr = 5'd31;
                    w_sel_data = pc_in + 32'd8;
                end
                default: begin
                    w_dec_we   = 1'b0;
                    w_dec_addr = 5'd0;
                    w_sel_data = 32'd0;
                end
            endcase
        end
    end

    // The immediate is already folded into AO_in upstream; keep it visible
    // on the port without letting it influence anything here.
    logic w_unused_ext;
    assign w_unused_ext = ^EXT32_in;

    // Writes to $0 and writes during reset are suppressed at the source so
    // forwarding never sees them.
    assign w_eff_we   = w_dec_we && ((w_op != COND_OP) || con_in) &&
                        (w_dec_addr != 5'd0) && reset;
    assign w_we_out   = w_eff_we;
    assign w_addr_out = w_eff_we ? w_dec_addr : 5'd0;
    assign w_data_out = w_sel_data;

    // Commit the W-stage result; async reset clears the whole file at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_grf[i] <= 32'd0;
            end
        end else if (w_eff_we) begin
            r_grf[w_addr_out] <= w_data_out;
        end
    end

    // Count every non-bubble instruction, including ones that do not write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instret <= 32'd0;
        end else if (instr_in != 32'd0) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign instret_out = r_instret;

    // Read port A with write-through bypass from the W stage.
    always_comb begin
        rs_data = 32'd0;
        if (reset && rs_addr != 5'd0) begin
            if (w_eff_we && rs_addr == w_addr_out) begin
                rs_data = w_data_out;
            end else begin
                rs_data = r_grf[rs_addr];
            end
        end
    end

    // Read port B, independent of port A.
    always_comb begin
        rt_data = 32'd0;
        if (reset && rt_addr != 5'd0) begin
            if (w_eff_we && rt_addr == w_addr_out) begin
                rt_data = w_data_out;
            end else begin
                rt_data = r_grf[rt_addr];
            end
        end
    end

endmodule

// File: tb/tb_w_stage_writeback.sv
// Scoreboard bench for w_stage_writeback: the driver pushes expected
// observations, a negedge monitor pops and compares them.
module tb_w_stage_writeback;

    logic        clk;
    logic        reset;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic [31:0] EXT32_in;
    logic [31:0] AO_in;
    logic [31:0] RD_in;
    logic        con_in;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        w_we_out;
    logic [4:0]  w_addr_out;
    logic [31:0] w_data_out;
    logic [31:0] instret_out;

    w_stage_writeback dut (
        .clk        (clk),
        .reset      (reset),
        .instr_in   (instr_in),
        .pc_in      (pc_in),
        .EXT32_in   (EXT32_in),
        .AO_in      (AO_in),
        .RD_in      (RD_in),
        .con_in     (con_in),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .w_we_out   (w_we_out),
        .w_addr_out (w_addr_out),
        .w_data_out (w_data_out),
        .instret_out(instret_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_RS = 0, S_RT = 1, S_WE = 2, S_ADDR = 3, S_DATA = 4, S_RET = 5;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic expect_v(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rt,
                                           input logic [15:0] imm);
        return {op, 5'd0, rt, imm};
    endfunction

    function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, 5'd1, 5'd2, rd, 5'd0, fn};
    endfunction

    // Monitor: compare every pending expectation against the settled outputs.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.sel)
                S_RS:    act = rs_data;
                S_RT:    act = rt_data;
                S_WE:    act = {31'd0, w_we_out};
                S_ADDR:  act = {27'd0, w_addr_out};
                S_DATA:  act = w_data_out;
                default: act = instret_out;
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        reset    = 1'b0;
        instr_in = 32'd0;
        pc_in    = 32'd0;
        EXT32_in = 32'd0;
        AO_in    = 32'd0;
        RD_in    = 32'd0;
        con_in   = 1'b0;
        rs_addr  = 5'd0;
        rt_addr  = 5'd0;
        step();
        rs_addr = 5'd5;
        expect_v("reset_instret", S_RET, 32'd0);
        expect_v("reset_rs", S_RS, 32'd0);
        expect_v("reset_we", S_WE, 32'd0);
        step();
        reset = 1'b1;

        // ori $5
        instr_in = i_type(6'h0d, 5'd5, 16'hBEEF);
        AO_in    = 32'h0000BEEF;
        expect_v("ori_bypass", S_RS, 32'h0000BEEF);
        expect_v("ori_we", S_WE, 32'd1);
        expect_v("ori_addr", S_ADDR, 32'd5);
        step();
        instr_in = 32'd0;
        expect_v("ori_array", S_RS, 32'h0000BEEF);
        expect_v("ori_nop_we", S_WE, 32'd0);
        expect_v("ori_instret", S_RET, 32'd1);

        // lw $8 selects memory data, not ALU result
        step();
        instr_in = i_type(6'h23, 5'd8, 16'h0);
        RD_in    = 32'h12345678;
        AO_in    = 32'hDEADBEEF;
        expect_v("lw_we", S_WE, 32'd1);
        expect_v("lw_addr", S_ADDR, 32'd8);
        expect_v("lw_data", S_DATA, 32'h12345678);
        step();
        instr_in = 32'd0;
        rt_addr  = 5'd8;
        expect_v("lw_array", S_RT, 32'h12345678);

        // jal, normal and wrapping
        step();
        instr_in = {6'h03, 26'h0};
        pc_in    = 32'h00003010;
        expect_v("jal_addr", S_ADDR, 32'd31);
        expect_v("jal_data", S_DATA, 32'h00003018);
        step();
        pc_in   = 32'hFFFFFFFC;
        rs_addr = 5'd31;
        expect_v("jal_bypass_wrap", S_RS, 32'h00000004);
        step();
        instr_in = 32'd0;
        expect_v("jal_array_wrap", S_RS, 32'h00000004);

        // conditional write
        step();
        instr_in = i_type(6'h3f, 5'd9, 16'h0);
        AO_in    = 32'd7;
        con_in   = 1'b0;
        rt_addr  = 5'd9;
        expect_v("cond0_we", S_WE, 32'd0);
        expect_v("cond0_addr", S_ADDR, 32'd0);
        expect_v("cond0_rt", S_RT, 32'd0);
        step();
        instr_in = 32'd0;
        expect_v("cond0_array", S_RT, 32'd0);
        step();
        instr_in = i_type(6'h3f, 5'd9, 16'h0);
        con_in   = 1'b1;
        expect_v("cond1_we", S_WE, 32'd1);
        step();
        instr_in = 32'd0;
        con_in   = 1'b0;
        expect_v("cond1_array", S_RT, 32'd7);

        // addu $0 then sw
        step();
        instr_in = r_type(5'd0, 6'h21);
        AO_in    = 32'hFFFFFFFF;
        rs_addr  = 5'd0;
        expect_v("r0_rs", S_RS, 32'd0);
        expect_v("r0_we", S_WE, 32'd0);
        expect_v("r0_addr", S_ADDR, 32'd0);
        step();
        instr_in = i_type(6'h2b, 5'd8, 16'h4);
        AO_in    = 32'h00000010;
        rt_addr  = 5'd8;
        expect_v("sw_we", S_WE, 32'd0);
        expect_v("sw_data", S_DATA, 32'd0);
        expect_v("sw_rt_keep", S_RT, 32'h12345678);
        step();
        instr_in = 32'd0;
        expect_v("sw_instret", S_RET, 32'd8);

        // subu $10, both ports bypass the same address
        step();
        instr_in = r_type(5'd10, 6'h23);
        AO_in    = 32'h00000055;
        rs_addr  = 5'd10;
        rt_addr  = 5'd10;
        expect_v("dual_rs", S_RS, 32'h00000055);
        expect_v("dual_rt", S_RT, 32'h00000055);
        step();

        // ori $3 then async reset between edges
        instr_in = i_type(6'h0d, 5'd3, 16'hA5A5);
        AO_in    = 32'hA5A5A5A5;
        step();
        instr_in = 32'd0;
        rs_addr  = 5'd3;
        expect_v("r3_array", S_RS, 32'hA5A5A5A5);
        expect_v("pre_reset_instret", S_RET, 32'd10);
        step();
        instr_in = i_type(6'h0d, 5'd4, 16'h0001);
        AO_in    = 32'd1;
        rt_addr  = 5'd4;
        #2;
        reset = 1'b0;
        #1;
        expect_v("async_r3", S_RS, 32'd0);
        expect_v("async_instret", S_RET, 32'd0);
        expect_v("async_we", S_WE, 32'd0);
        step();
        reset    = 1'b1;
        instr_in = 32'd0;
        expect_v("discard_r4", S_RT, 32'd0);
        expect_v("post_reset_instret", S_RET, 32'd0);

        // first edge after release commits
        step();
        instr_in = i_type(6'h0f, 5'd6, 16'h0066);
        AO_in    = 32'h00660000;
        rs_addr  = 5'd6;
        step();
        instr_in = 32'd0;
        expect_v("first_commit", S_RS, 32'h00660000);
        expect_v("first_instret", S_RET, 32'd1);

        // instret wrap via preload
        step();
        force dut.r_instret = 32'hFFFFFFFF;
        #1;
        release dut.r_instret;
        instr_in = i_type(6'h0d, 5'd7, 16'h0001);
        expect_v("preload_instret", S_RET, 32'hFFFFFFFF);
        step();
        instr_in = 32'd0;
        expect_v("wrap_instret", S_RET, 32'd0);
        step();
        step();
    end

    // Finish once the driver has drained; bounded so the run always ends.
    initial begin
        int budget;
        budget = 0;
        #20;
        while ((q.size() != 0 || $time < 500) && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        repeat (4) @(posedge clk);
        if (budget >= 2000 || q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: pending=%0d expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
